// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module  : dmem_responder_pkg
// Brief   : Shared state encodings, counter width and helpers for the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module  : dmem_array
// Brief   : Single-port DEPTH x DATA_W storage, synchronous write, registered read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            if (rd_clr) begin
                rdata_d = '0;
            end else if (!we) begin
                rdata_d = mem_q[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : MEM-stage load/store responder with programmable wait states and pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err
);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_latency_range_err
            $error("dmem_responder: LATENCY must be in 0..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;

    logic               commit;
    logic               cur_we;
    logic [ADDR_W+1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic               cur_mis;
    logic               mem_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        commit    = 1'b0;
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                // With zero latency the commit happens on the accept edge, so the
                // live request feeds the array rather than the not-yet-latched copy.
                cur_we    = req_we;
                cur_addr  = req_addr[ADDR_W+1:0];
                cur_wdata = req_wdata;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cur_mis = is_misaligned(cur_addr[1:0]);
        if (commit && cur_mis) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Reset on the commit edge abandons the transaction, including its store.
    assign mem_en = commit && !reset;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .en     (mem_en),
        .we     (cur_we && !cur_mis),
        .rd_clr (cur_mis),
        .addr   (cur_addr[ADDR_W+1:2]),
        .wdata  (cur_wdata),
        .rdata  (resp_rdata)
    );

    assign stall      = (state_q == ST_IDLE && req_valid) || (state_q == ST_BUSY);
    assign resp_valid = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder (LATENCY=2 and LATENCY=0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_stall, z_resp_valid, z_err;
    logic [31:0] z_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err)
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_we     (z_req_we),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .stall      (z_stall),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .err        (z_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and checks the full stall/resp_valid/err timeline.
    // The request is left asserted so a following call forms a back-to-back pair.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic chk_rd,
                       input logic [31:0] exp_rd, input logic err_pre, input logic err_post);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check({tag, ".stall"}, {31'd0, stall}, 32'd1);
            check({tag, ".rv_lo"}, {31'd0, resp_valid}, 32'd0);
            check({tag, ".err_pre"}, {31'd0, err}, {31'd0, err_pre});
            next_cycle();
        end
        @(negedge clk);
        check({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
        check({tag, ".rv_hi"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".err_post"}, {31'd0, err}, {31'd0, err_post});
        if (chk_rd) check({tag, ".rdata"}, resp_rdata, exp_rd);
        next_cycle();
    endtask

    task automatic go_idle(input string tag);
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, ".idle_stall"}, {31'd0, stall}, 32'd0);
        check({tag, ".idle_rv"}, {31'd0, resp_valid}, 32'd0);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst.stall", {31'd0, stall}, 32'd0);
        check("rst.rv", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err", {31'd0, err}, 32'd0);
        next_cycle();

        // Store/load round trip, plus the word used later by the reset test
        txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        go_idle("st10");
        txn("ld10", 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        go_idle("ld10");
        txn("st20", 1'b1, 32'h20, 32'h66, 1'b0, 32'h0, 1'b0, 1'b0);
        go_idle("st20");

        // Back-to-back stores with req_valid held; second accept lands in T+4
        txn("bb4", 1'b1, 32'h4, 32'h11, 1'b0, 32'h0, 1'b0, 1'b0);
        txn("bb8", 1'b1, 32'h8, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0);
        go_idle("bb");
        txn("ld4", 1'b0, 32'h4, 32'h0, 1'b1, 32'h11, 1'b0, 1'b0);
        txn("ld8", 1'b0, 32'h8, 32'h0, 1'b1, 32'h22, 1'b0, 1'b0);
        go_idle("ld8");

        // 0x400 aliases word 0 with 8 address bits
        txn("st400", 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b0);
        go_idle("st400");
        txn("ld0", 1'b0, 32'h0, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        go_idle("ld0");

        // Misaligned store: zero read data, sticky err, no write
        txn("mis", 1'b1, 32'h13, 32'h55, 1'b1, 32'h0, 1'b0, 1'b1);
        go_idle("mis");
        txn("ld10b", 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        go_idle("ld10b");

        // Reset during BUSY abandons the store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h77;
        @(negedge clk);
        check("rb.accept", {31'd0, stall}, 32'd1);
        next_cycle();
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rb.busy", {31'd0, stall}, 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rb.stall", {31'd0, stall}, 32'd0);
        check("rb.rv", {31'd0, resp_valid}, 32'd0);
        check("rb.err", {31'd0, err}, 32'd0);
        check("rb.rdata", resp_rdata, 32'd0);
        next_cycle();
        txn("ld20", 1'b0, 32'h20, 32'h0, 1'b1, 32'h66, 1'b0, 1'b0);
        go_idle("ld20");

        // LATENCY=0 instance
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h30; z_req_wdata = 32'h1234;
        @(negedge clk);
        check("z.st.stall", {31'd0, z_stall}, 32'd1);
        check("z.st.rv_lo", {31'd0, z_resp_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("z.st.stall_done", {31'd0, z_stall}, 32'd0);
        check("z.st.rv_hi", {31'd0, z_resp_valid}, 32'd1);
        next_cycle();
        z_req_valid = 1'b0;
        @(negedge clk);
        check("z.no_reaccept", {31'd0, z_resp_valid}, 32'd0);
        next_cycle();
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h30; z_req_wdata = 32'h0;
        @(negedge clk);
        check("z.ld.stall", {31'd0, z_stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("z.ld.rv_hi", {31'd0, z_resp_valid}, 32'd1);
        check("z.ld.rdata", z_resp_rdata, 32'h1234);
        check("z.ld.err", {31'd0, z_err}, 32'd0);
        next_cycle();
        z_req_valid = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
